rx_medida_7e1: RTL and testbench

- Receiver for the ASCII measurement frame sent by the ultrasonic range-meter datapath.
- Frame format: three ASCII decimal digits (hundreds, tens, units) followed by '#' (0x23).
- Each character travels over the 7E1 serial link: start bit, 7 data bits LSB-first, even parity, one stop bit.
- The block deserializes the characters, checks parity, framing and format, and presents the measurement as 12-bit BCD with a one-cycle valid pulse. It sits on the host/test side of the serial link, e.g. a second board or a loopback in the top level.

---
 rtl/rx_medida_7e1.sv | 249 ++++++++++++++++++++++++
 tb/tb_rx_medida_7e1.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_medida_7e1.sv
// rx_medida_7e1: receiver for the ASCII range-meter frame "DDD#" over a 7E1 serial link.
//
// Ports:
//   i_clock           system clock
//   i_reset           synchronous, active-high; clears all state and outputs
//   i_entrada_serial  serial line, idles high, asynchronous to i_clock
//   o_medida          last valid measurement, BCD {hundreds, tens, units}
//   o_medida_valida   one-cycle pulse when o_medida is updated
//   o_erro_paridade   one-cycle pulse: even-parity check failed
//   o_erro_quadro     one-cycle pulse: stop bit sampled as 0
//   o_erro_formato    one-cycle pulse: character unexpected for the frame position
//   o_ocupado         high from start detect to stop sample
//   o_db_estado       debug: [3:2] bit-receiver state, [1:0] parser state
module rx_medida_7e1 #(
  parameter int unsigned M_BAUD = 434,
  parameter int unsigned N_BAUD = 9
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_entrada_serial,
  output logic [11:0] o_medida,
  output logic        o_medida_valida,
  output logic        o_erro_paridade,
  output logic        o_erro_quadro,
  output logic        o_erro_formato,
  output logic        o_ocupado,
  output logic [3:0]  o_db_estado
);

  localparam logic [N_BAUD-1:0] CntHalf = N_BAUD'(M_BAUD / 2 - 1);
  localparam logic [N_BAUD-1:0] CntFull = N_BAUD'(M_BAUD - 1);
  localparam logic [6:0]        ChFim   = 7'h23;

  typedef enum logic [2:0] {
    RxOcioso, RxInicio, RxDados, RxParidade, RxParada
  } rx_estado_e;

  typedef enum logic [1:0] {
    PsEspC = 2'd0, PsEspD = 2'd1, PsEspU = 2'd2, PsEspFim = 2'd3
  } ps_estado_e;

  // Synchronizer
  logic r_sync1, r_sync2;
  logic w_s;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_entrada_serial;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;

  // Bit receiver
  rx_estado_e        r_rx_estado;
  logic [N_BAUD-1:0] r_cnt;
  logic [2:0]        r_nbit;
  logic [6:0]        r_dados;
  logic              r_par;
  logic              r_ocupado;

  logic w_tick;
  logic w_char_ok;
  logic w_err_par;
  logic w_err_stop;

  assign w_tick     = (r_cnt == '0);
  // The character is handed to the parser combinationally during the stop-sample cycle so
  // that the registered parser pulses land on the edge right after that sample.
  assign w_char_ok  = (r_rx_estado == RxParada) && w_tick;
  assign w_err_par  = ^{r_dados, r_par};
  assign w_err_stop = ~w_s;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rx_estado <= RxOcioso;
      r_cnt       <= '0;
      r_nbit      <= '0;
      r_dados     <= '0;
      r_par       <= 1'b0;
      r_ocupado   <= 1'b0;
    end else begin
      unique case (r_rx_estado)
        RxOcioso: begin
          if (!w_s) begin
            r_cnt       <= CntHalf;
            r_rx_estado <= RxInicio;
            r_ocupado   <= 1'b1;
          end
        end
        RxInicio: begin
          if (w_tick) begin
            if (w_s) begin
              // False start: drop back silently.
              r_rx_estado <= RxOcioso;
              r_ocupado   <= 1'b0;
            end else begin
              r_cnt       <= CntFull;
              r_nbit      <= '0;
              r_rx_estado <= RxDados;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RxDados: begin
          if (w_tick) begin
            r_dados <= {w_s, r_dados[6:1]};
            r_cnt   <= CntFull;
            if (r_nbit == 3'd6) begin
              r_rx_estado <= RxParidade;
            end else begin
              r_nbit <= r_nbit + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RxParidade: begin
          if (w_tick) begin
            r_par       <= w_s;
            r_cnt       <= CntFull;
            r_rx_estado <= RxParada;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RxParada: begin
          if (w_tick) begin
            r_rx_estado <= RxOcioso;
            r_ocupado   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_rx_estado <= RxOcioso;
          r_ocupado   <= 1'b0;
        end
      endcase
    end
  end

  // Parser
  ps_estado_e  r_ps;
  logic [3:0]  r_cent, r_dez, r_uni;
  logic [11:0] r_medida;
  logic        r_valida, r_e_par, r_e_quadro, r_e_formato;
  logic        w_digito;

  assign w_digito = (r_dados[6:4] == 3'b011) && (r_dados[3:0] <= 4'd9);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ps        <= PsEspC;
      r_cent      <= '0;
      r_dez       <= '0;
      r_uni       <= '0;
      r_medida    <= '0;
      r_valida    <= 1'b0;
      r_e_par     <= 1'b0;
      r_e_quadro  <= 1'b0;
      r_e_formato <= 1'b0;
    end else begin
      r_valida    <= 1'b0;
      r_e_par     <= 1'b0;
      r_e_quadro  <= 1'b0;
      r_e_formato <= 1'b0;
      if (w_char_ok) begin
        // At most one error pulse per character: framing, then parity, then format.
        if (w_err_stop) begin
          r_e_quadro <= 1'b1;
          r_ps       <= PsEspC;
        end else if (w_err_par) begin
          r_e_par <= 1'b1;
          r_ps    <= PsEspC;
        end else begin
          unique case (r_ps)
            PsEspC: begin
              if (w_digito) begin
                r_cent <= r_dados[3:0];
                r_ps   <= PsEspD;
              end else begin
                r_e_formato <= 1'b1;
                r_ps        <= PsEspC;
              end
            end
            PsEspD: begin
              if (w_digito) begin
                r_dez <= r_dados[3:0];
                r_ps  <= PsEspU;
              end else begin
                r_e_formato <= 1'b1;
                r_ps        <= PsEspC;
              end
            end
            PsEspU: begin
              if (w_digito) begin
                r_uni <= r_dados[3:0];
                r_ps  <= PsEspFim;
              end else begin
                r_e_formato <= 1'b1;
                r_ps        <= PsEspC;
              end
            end
            PsEspFim: begin
              if (r_dados == ChFim) begin
                r_medida <= {r_cent, r_dez, r_uni};
                r_valida <= 1'b1;
              end else begin
                r_e_formato <= 1'b1;
              end
              r_ps <= PsEspC;
            end
            default: r_ps <= PsEspC;
          endcase
        end
      end
    end
  end

  // Five receiver states squeezed into two debug bits: parity and stop share code 3.
  logic [1:0] w_rx_dbg;

  always_comb begin
    w_rx_dbg = 2'd0;
    unique case (r_rx_estado)
      RxOcioso:   w_rx_dbg = 2'd0;
      RxInicio:   w_rx_dbg = 2'd1;
      RxDados:    w_rx_dbg = 2'd2;
      RxParidade: w_rx_dbg = 2'd3;
      RxParada:   w_rx_dbg = 2'd3;
      default:    w_rx_dbg = 2'd0;
    endcase
  end

  assign o_medida        = r_medida;
  assign o_medida_valida = r_valida;
  assign o_erro_paridade = r_e_par;
  assign o_erro_quadro   = r_e_quadro;
  assign o_erro_formato  = r_e_formato;
  assign o_ocupado       = r_ocupado;
  assign o_db_estado     = {w_rx_dbg, r_ps};

endmodule

// File: tb/tb_rx_medida_7e1.sv
// Testbench for rx_medida_7e1: directed frames, scoreboard of expected output pulses.
module tb_rx_medida_7e1;

  localparam int unsigned MB = 8;
  localparam int unsigned NB = 4;

  localparam logic [3:0] KVal = 4'b1000;
  localparam logic [3:0] KPar = 4'b0100;
  localparam logic [3:0] KQua = 4'b0010;
  localparam logic [3:0] KFmt = 4'b0001;
  localparam logic [3:0] KNone = 4'b0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        line;
  logic [11:0] medida;
  logic        valida, e_par, e_qua, e_fmt, ocupado;
  logic [3:0]  db;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0]  kind;
    logic [11:0] med;
    int          cyc;
  } ev_t;

  ev_t q[$];
  logic [11:0] cur_med;

  rx_medida_7e1 #(
    .M_BAUD(MB),
    .N_BAUD(NB)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_entrada_serial(line),
    .o_medida        (medida),
    .o_medida_valida (valida),
    .o_erro_paridade (e_par),
    .o_erro_quadro   (e_qua),
    .o_erro_formato  (e_fmt),
    .o_ocupado       (ocupado),
    .o_db_estado     (db)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every output pulse must match the oldest expected event, including timing.
  always @(negedge clk) begin
    if (valida || e_par || e_qua || e_fmt) begin
      chk("pulse_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        ev_t e;
        e = q.pop_front();
        chk("pulse_kind", 32'({valida, e_par, e_qua, e_fmt}), 32'(e.kind));
        chk("pulse_medida", 32'(medida), 32'(e.med));
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // One 7E1 character; stop bit sample lands 3 + MB/2 + 9*MB edges after the start edge.
  task automatic send_char(input logic [6:0] c, input logic [3:0] ek, input logic [11:0] em,
                           input bit fpar = 1'b0, input bit stop0 = 1'b0);
    logic [9:0] bits;
    ev_t e;
    bits = {~stop0, (^c) ^ fpar, c, 1'b0};
    @(posedge clk); #1;
    line = bits[0];
    if (ek != KNone) begin
      e.kind = ek;
      e.med  = em;
      e.cyc  = cyc + 3 + MB / 2 + 9 * MB;
      q.push_back(e);
    end
    for (int i = 1; i < 10; i++) begin
      repeat (MB) @(posedge clk);
      #1 line = bits[i];
    end
    repeat (MB) @(posedge clk);
    #1 line = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_medida"}, 32'(medida), 32'h000);
    chk({tag, "_pulses"}, 32'({valida, e_par, e_qua, e_fmt}), 32'd0);
    chk({tag, "_ocupado"}, 32'(ocupado), 32'd0);
    chk({tag, "_db"}, 32'(db), 32'd0);
  endtask

  initial begin
    rst  = 1'b1;
    line = 1'b1;
    cur_med = 12'h000;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Plain frame
    send_char("1", KNone, cur_med);
    send_char("2", KNone, cur_med);
    send_char("3", KNone, cur_med);
    send_char("#", KVal, 12'h123);
    cur_med = 12'h123;

    // Parity error in the middle, '#' then lands in ESP_D
    send_char("1", KNone, cur_med);
    send_char("2", KPar, cur_med, 1'b1);
    send_char("3", KNone, cur_med);
    send_char("#", KFmt, cur_med);
    send_char("0", KNone, cur_med);
    send_char("4", KNone, cur_med);
    send_char("5", KNone, cur_med);
    send_char("#", KVal, 12'h045);
    cur_med = 12'h045;

    // Format errors and resynchronisation
    send_char("1", KNone, cur_med);
    send_char("A", KFmt, cur_med);
    send_char("3", KNone, cur_med);
    send_char("#", KFmt, cur_med);
    send_char("1", KNone, cur_med);
    send_char("2", KNone, cur_med);
    send_char("#", KFmt, cur_med);
    send_char("7", KNone, cur_med);
    send_char("8", KNone, cur_med);
    send_char("9", KNone, cur_med);
    send_char("#", KVal, 12'h789);
    cur_med = 12'h789;

    // Short glitch: start detected, then rejected as false start
    @(posedge clk); #1 line = 1'b0;
    repeat (3) @(posedge clk);
    #1 line = 1'b1;
    chk("glitch_ocupado_hi", 32'(ocupado), 32'd1);
    repeat (20) @(posedge clk);
    #1 chk("glitch_ocupado_lo", 32'(ocupado), 32'd0);
    chk("glitch_medida", 32'(medida), 32'(cur_med));
    send_char("9", KNone, cur_med);
    send_char("9", KNone, cur_med);
    send_char("9", KNone, cur_med);
    send_char("#", KVal, 12'h999);
    cur_med = 12'h999;

    // Framing error on '#'
    send_char("4", KNone, cur_med);
    send_char("5", KNone, cur_med);
    send_char("6", KNone, cur_med);
    send_char("#", KQua, cur_med, 1'b0, 1'b1);
    repeat (2 * MB) @(posedge clk);
    #1 chk("quadro_medida_hold", 32'(medida), 32'(cur_med));
    send_char("4", KNone, cur_med);
    send_char("5", KNone, cur_med);
    send_char("6", KNone, cur_med);
    send_char("#", KVal, 12'h456);
    cur_med = 12'h456;

    // Reset during the data bits of the second character
    send_char("3", KNone, cur_med);
    begin
      logic [6:0] c2;
      c2 = "2";
      @(posedge clk); #1 line = 1'b0;
      for (int i = 0; i < 3; i++) begin
        repeat (MB) @(posedge clk);
        #1 line = c2[i];
      end
      repeat (MB) @(posedge clk);
      #1 chk("mid_ocupado", 32'(ocupado), 32'd1);
      chk("mid_db", 32'(db), 32'b1001);
    end
    rst  = 1'b1;
    line = 1'b1;
    @(posedge clk);
    #1 chk_zero("midreset");
    repeat (2) @(posedge clk);
    #1 chk_zero("midreset2");
    rst = 1'b0;
    cur_med = 12'h000;
    repeat (4) @(posedge clk);
    send_char("6", KNone, cur_med);
    send_char("5", KNone, cur_med);
    send_char("4", KNone, cur_med);
    send_char("#", KVal, 12'h654);
    cur_med = 12'h654;

    repeat (3 * MB) @(posedge clk);
    #1 chk("queue_drained", 32'(q.size()), 32'd0);
    chk("final_medida", 32'(medida), 32'h654);
    chk("final_quiet", 32'({valida, e_par, e_qua, e_fmt, ocupado}), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
